// File: rtl/const_load_seq.sv
// Two-write constant materialiser: upper-immediate write followed by the full value.
// Optional CONST_LOAD_SKIP_ZERO_LOWER_EN drops the second write when the lower half is zero.
module const_load_seq #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] req_dest,
  input  logic [DATA_W-1:0] req_const,
  output logic              rf_req,
  input  logic              rf_gnt,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done
);

  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {IDLE, UPPER, LOWER, FIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] const_q;
  logic              accept;
  logic              skip_lower;

`ifdef CONST_LOAD_SKIP_ZERO_LOWER_EN
  assign skip_lower = (const_q[HALF_W-1:0] == '0);
`else
  assign skip_lower = 1'b0;
`endif

  // Request operands are captured only on accept and held for the whole sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dest_q  <= '0;
      const_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dest_q  <= req_dest;
        const_q <= req_const;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_ready = 1'b0;
    rf_req    = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          // Register zero is hardwired, so such a request completes without writing.
          state_nxt = (req_dest == '0) ? FIN : UPPER;
        end
      end
      UPPER: begin
        rf_req   = 1'b1;
        rf_waddr = dest_q;
        rf_wdata = {const_q[DATA_W-1:HALF_W], {HALF_W{1'b0}}};
        if (rf_gnt) state_nxt = skip_lower ? FIN : LOWER;
      end
      LOWER: begin
        rf_req   = 1'b1;
        rf_waddr = dest_q;
        rf_wdata = {const_q[DATA_W-1:HALF_W], {HALF_W{1'b0}}}
                 | {{HALF_W{1'b0}}, const_q[HALF_W-1:0]};
        if (rf_gnt) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rf_we = rf_req & rf_gnt;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_const_load_seq.sv
// Bench for const_load_seq: directed and randomized loads checked against an
// expected-write-list model built from the block's load rules.
module tb_const_load_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_dest = '0;
  logic [31:0] req_const = '0;
  logic        rf_req;
  logic        rf_gnt = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = -1;
  int last_done = 0;
  bit skip_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  const_load_seq #(.REG_AW(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_const(req_const), .rf_req(rf_req), .rf_gnt(rf_gnt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // One load: model lists the expected writes, gnt is withheld 'hold' cycles per write.
  task automatic do_txn(input logic [4:0] d, input logic [31:0] c, input int hold, input bit hv);
    logic [31:0] wq[$];
    int done_k;
    int wait_ctr;
    int acc;
    logic pend;
    if (d != 5'd0) begin
      wq.push_back({c[31:16], 16'h0000});
      if (!(skip_en && c[15:0] == 16'h0000)) wq.push_back(c);
    end
    done_k = 1 + wq.size() * (hold + 1);
    @(negedge clk);
    req_valid = 1'b1;
    req_dest  = d;
    req_const = c;
    rf_gnt    = 1'b0;
    #1;
    chk("ready_idle", 32'(req_ready), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    acc = cyc;
    if (hv && last_acc >= 0) chk("accept_spacing", 32'(acc - last_acc), 32'(last_done + 1));
    last_acc  = acc;
    last_done = done_k;
    wait_ctr  = 0;
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      req_dest  = 5'($urandom);
      req_const = $urandom;
      req_valid = hv ? 1'b1 : 1'($urandom);
      pend = (wq.size() > 0);
      if (pend) rf_gnt = (wait_ctr == hold);
      else      rf_gnt = 1'($urandom);
      #1;
      chk("rf_req", 32'(rf_req), 32'(pend));
      chk("rf_we", 32'(rf_we), 32'(pend && rf_gnt));
      chk("rf_waddr", 32'(rf_waddr), pend ? 32'(d) : 32'd0);
      chk("rf_wdata", rf_wdata, pend ? wq[0] : 32'd0);
      chk("done", 32'(done), 32'(k == done_k));
      chk("busy", 32'(busy), 32'd1);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (pend) begin
        if (rf_gnt) begin
          void'(wq.pop_front());
          wait_ctr = 0;
        end else begin
          wait_ctr++;
        end
      end
    end
  endtask

  initial begin
`ifdef CONST_LOAD_SKIP_ZERO_LOWER_EN
    skip_en = 1'b1;
`else
    skip_en = 1'b0;
`endif
    // Reset: outputs idle even with requests and grants present.
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_dest = 5'd8;
    req_const = 32'h1234ABCD;
    rf_gnt = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rf_req", 32'(rf_req), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rf_gnt = 1'b0;
    rst_n = 1'b1;

    do_txn(5'd8, 32'h1234ABCD, 0, 1'b0);
    do_txn(5'd0, 32'hFFFFFFFF, 0, 1'b0);
    do_txn(5'd5, 32'hDEADBEEF, 5, 1'b0);
    do_txn(5'd3, 32'h00050000, 0, 1'b0);

    // Continuous request stream with changing constants.
    last_acc = -1;
    for (int i = 0; i < 5; i++) do_txn(5'($urandom_range(1, 31)), $urandom, 0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      logic [4:0]  d;
      logic [31:0] c;
      d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      c = $urandom;
      if ($urandom_range(0, 2) == 0) c[15:0] = 16'h0000;
      do_txn(d, c, $urandom_range(0, 3), 1'b0);
    end

    // Reset while the lower write is pending must abort without a done pulse.
    @(negedge clk);
    req_valid = 1'b1;
    req_dest = 5'd9;
    req_const = 32'h55AA1234;
    rf_gnt = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rf_gnt = 1'b1;
    #1;
    chk("abort_upper_we", 32'(rf_we), 32'd1);
    @(negedge clk);
    rf_gnt = 1'b1;
    #1;
    chk("abort_lower_data", rf_wdata, 32'h55AA1234);
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(rf_we), 32'd0);
    chk("abort_rf_req", 32'(rf_req), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("abort_hold_done", 32'(done), 32'd0);
      chk("abort_hold_we", 32'(rf_we), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rf_gnt = 1'b0;
    #1;
    chk("release_ready", 32'(req_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("release_no_done", 32'(done), 32'd0);
    do_txn(5'd9, 32'hCAFE0000, 0, 1'b0);

    @(negedge clk);
    req_valid = 1'b0;
    rf_gnt = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
